// File: rtl/ah_cam_wr_credit_feeder.sv
// Credit-gated write feeder for the AH CAM: buffers producer writes in a small FIFO
// and strobes them into the CAM one per cycle while write credits remain.
module ah_cam_wr_credit_feeder #(
    parameter int DW      = 16,
    parameter int FDEPTH  = 4,
    parameter int CREDITS = 10,
    parameter int CW      = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              in_data,
    input  logic                       flush,
    output logic                       wvalid,
    output logic [DW-1:0]              wdata,
    input  logic                       wcredit,
    output logic [CW-1:0]              credit_cnt,
    output logic [$clog2(FDEPTH):0]    fifo_cnt,
    output logic                       credit_err
);

    localparam int AW = $clog2(FDEPTH);

    typedef enum logic {AVAIL, STALL} credit_state_t;

    credit_state_t state, state_next;

    logic [DW-1:0] mem [FDEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          push, issue;
    logic [CW-1:0] credit_next;
    logic          credit_ovf;

    // Returns {overflow, next count}; a return at the full count saturates.
    function automatic logic [CW:0] credit_step(input logic [CW-1:0] cnt,
                                                input logic          take,
                                                input logic          give);
        logic [CW-1:0] nxt;
        logic          ovf;
        nxt = cnt;
        ovf = 1'b0;
        if (take && !give) begin
            nxt = cnt - CW'(1);
        end else if (give && !take) begin
            if (cnt == CW'(CREDITS)) ovf = 1'b1;
            else                     nxt = cnt + CW'(1);
        end
        return {ovf, nxt};
    endfunction

    // Ready comes from the registered count only, so a full FIFO refuses a push
    // even in a cycle that also pops.
    assign in_ready = ~rst & (fifo_cnt != (AW+1)'(FDEPTH));
    assign push     = in_valid & in_ready & ~flush;
    assign issue    = (fifo_cnt != '0) & (state == AVAIL) & ~flush;

    always_comb begin
        state_next                = state;
        {credit_ovf, credit_next} = credit_step(credit_cnt, issue, wcredit);
        if (credit_next == '0) state_next = STALL;
        else                   state_next = AVAIL;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= AVAIL;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_cnt   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            credit_cnt <= CW'(CREDITS);
            wvalid     <= 1'b0;
            wdata      <= '0;
            credit_err <= 1'b0;
        end else begin
            if (flush) begin
                fifo_cnt <= '0;
                rd_ptr   <= wr_ptr;
            end else begin
                if (push)  wr_ptr <= wr_ptr + AW'(1);
                if (issue) rd_ptr <= rd_ptr + AW'(1);
                fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(issue);
            end
            wvalid <= issue;
            if (issue) wdata <= mem[rd_ptr];
            credit_cnt <= credit_next;
            if (credit_ovf) credit_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ah_cam_wr_credit_feeder.sv
// Bench for ah_cam_wr_credit_feeder: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based model.
module tb_ah_cam_wr_credit_feeder;

    localparam int DW      = 16;
    localparam int FDEPTH  = 4;
    localparam int CREDITS = 10;
    localparam int CW      = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          flush = 1'b0;
    logic          wvalid;
    logic [DW-1:0] wdata;
    logic          wcredit = 1'b0;
    logic [CW-1:0] credit_cnt;
    logic [2:0]    fifo_cnt;
    logic          credit_err;

    always #5 clk = ~clk;

    ah_cam_wr_credit_feeder #(.DW(DW), .FDEPTH(FDEPTH), .CREDITS(CREDITS), .CW(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush), .wvalid(wvalid), .wdata(wdata), .wcredit(wcredit),
        .credit_cnt(credit_cnt), .fifo_cnt(fifo_cnt), .credit_err(credit_err)
    );

    int vectors = 0;
    int errs    = 0;
    int wv_seen = 0;
    int acc_n   = 0;

    // Behavioural model: a queue of pending words and an integer credit pool.
    logic [DW-1:0] q[$];
    int            m_cr = CREDITS;
    logic          m_wv = 1'b0;
    logic [DW-1:0] m_wd = '0;
    logic          m_err = 1'b0;
    bit            m_valid = 1'b0;

    typedef struct {
        logic          r, v;
        logic [DW-1:0] d;
        logic          fl, wc;
        logic          e_rdy, e_wv;
        logic [DW-1:0] e_wd;
        int            e_cr, e_fc;
        logic          e_err;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [DW-1:0] d,
                         input logic fl, input logic wc);
        rst = r; in_valid = v; in_data = d; flush = fl; wcredit = wc;
        #1;
        if (m_valid) begin
            check("model_in_ready", 32'(in_ready), 32'(!r && q.size() != FDEPTH));
            check("model_wvalid", 32'(wvalid), 32'(m_wv));
            check("model_wdata", 32'(wdata), 32'(m_wd));
            check("model_credit_cnt", 32'(credit_cnt), 32'(m_cr));
            check("model_fifo_cnt", 32'(fifo_cnt), 32'(q.size()));
            check("model_credit_err", 32'(credit_err), 32'(m_err));
        end
        if (wvalid === 1'b1) wv_seen++;
    endtask

    task automatic advance();
        bit acc, iss;
        if (rst) begin
            q.delete();
            m_cr = CREDITS; m_wv = 1'b0; m_wd = '0; m_err = 1'b0; m_valid = 1'b1;
        end else begin
            acc = in_valid && q.size() != FDEPTH && !flush;
            iss = q.size() != 0 && m_cr != 0 && !flush;
            m_wv = iss;
            if (iss) m_wd = q.pop_front();
            if (flush) q.delete();
            if (acc) begin
                q.push_back(in_data);
                acc_n++;
            end
            if (wcredit && !iss && m_cr == CREDITS) m_err = 1'b1;
            else m_cr = m_cr - int'(iss) + int'(wcredit);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                        input logic fl, input logic wc);
        drive(r, v, d, fl, wc);
        advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, '0, 0, 0);
        wv_seen = 0;
        acc_n   = 0;
    endtask

    // Push until 'n' words have been accepted, bounded by a cycle budget.
    task automatic push_words(input int n, input logic [DW-1:0] base);
        int start;
        start = acc_n;
        for (int k = 0; k < 64 && (acc_n - start) < n; k++)
            step(0, 1, base + DW'(acc_n - start), 0, 0);
        check("push_budget", 32'(acc_n - start), 32'(n));
    endtask

    initial begin
        bit chk_next, done;
        int snap;

        tbl[0]  = '{1, 0, 16'h0000, 0, 0,  0, 0, 16'h0000, 10, 0, 0};
        tbl[1]  = '{0, 1, 16'h0011, 0, 0,  1, 0, 16'h0000, 10, 0, 0};
        tbl[2]  = '{0, 1, 16'h0022, 0, 0,  1, 0, 16'h0000, 10, 1, 0};
        tbl[3]  = '{0, 1, 16'h0033, 0, 0,  1, 1, 16'h0011,  9, 1, 0};
        tbl[4]  = '{0, 0, 16'h0000, 0, 0,  1, 1, 16'h0022,  8, 1, 0};
        tbl[5]  = '{0, 0, 16'h0000, 0, 0,  1, 1, 16'h0033,  7, 0, 0};
        tbl[6]  = '{0, 0, 16'h0000, 0, 1,  1, 0, 16'h0033,  7, 0, 0};
        tbl[7]  = '{0, 0, 16'h0000, 0, 1,  1, 0, 16'h0033,  8, 0, 0};
        tbl[8]  = '{0, 0, 16'h0000, 0, 1,  1, 0, 16'h0033,  9, 0, 0};
        tbl[9]  = '{0, 0, 16'h0000, 0, 1,  1, 0, 16'h0033, 10, 0, 0};
        tbl[10] = '{0, 0, 16'h0000, 0, 0,  1, 0, 16'h0033, 10, 0, 1};
        tbl[11] = '{1, 0, 16'h0000, 0, 0,  0, 0, 16'h0033, 10, 0, 1};
        tbl[12] = '{0, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 10, 0, 0};

        step(1, 0, '0, 0, 0);

        // Directed vector table: three-word burst, credit refill, credit_err, reset.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].wc);
            check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_wvalid", i), 32'(wvalid), 32'(tbl[i].e_wv));
            check($sformatf("tbl%0d_wdata", i), 32'(wdata), 32'(tbl[i].e_wd));
            check($sformatf("tbl%0d_credit_cnt", i), 32'(credit_cnt), 32'(tbl[i].e_cr));
            check($sformatf("tbl%0d_fifo_cnt", i), 32'(fifo_cnt), 32'(tbl[i].e_fc));
            check($sformatf("tbl%0d_credit_err", i), 32'(credit_err), 32'(tbl[i].e_err));
            advance();
        end

        // Twelve words with no credit returns: ten issued, two held.
        do_reset();
        push_words(12, 16'h0100);
        idle(3);
        drive(0, 0, '0, 0, 0);
        check("burst12_pulses", 32'(wv_seen), 32'd10);
        check("burst12_credit", 32'(credit_cnt), 32'd0);
        check("burst12_fifo", 32'(fifo_cnt), 32'd2);
        advance();
        step(0, 0, '0, 0, 1);
        idle(3);
        drive(0, 0, '0, 0, 0);
        check("one_credit_pulses", 32'(wv_seen), 32'd11);
        check("one_credit_credit", 32'(credit_cnt), 32'd0);
        check("one_credit_fifo", 32'(fifo_cnt), 32'd1);
        advance();

        // Fill to full while stalled; a push into the full FIFO is dropped.
        push_words(3, 16'h0200);
        drive(0, 1, 16'hDEAD, 0, 0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_fifo", 32'(fifo_cnt), 32'd4);
        advance();
        for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 1);
        idle(3);
        drive(0, 0, '0, 0, 0);
        check("drain_pulses", 32'(wv_seen), 32'd15);
        check("drain_fifo", 32'(fifo_cnt), 32'd0);
        advance();

        // Credit return coinciding with an issue at credit_cnt==5.
        do_reset();
        chk_next = 0;
        done = 0;
        for (int k = 0; k < 16; k++) begin
            logic wc;
            wc = (!done && m_cr == 5 && q.size() != 0);
            drive(0, (k < 8), 16'h0300 + DW'(k), 0, wc);
            if (chk_next) begin
                check("credit_same_cycle", 32'(credit_cnt), 32'd5);
                chk_next = 0;
            end
            if (wc) begin
                chk_next = 1;
                done = 1;
            end
            advance();
        end

        // Flush three stalled words; later credits must not produce writes.
        do_reset();
        push_words(13, 16'h0400);
        idle(3);
        drive(0, 0, '0, 0, 0);
        check("preflush_fifo", 32'(fifo_cnt), 32'd3);
        check("preflush_credit", 32'(credit_cnt), 32'd0);
        advance();
        step(0, 1, 16'hBEEF, 1, 0);
        drive(0, 0, '0, 0, 0);
        check("postflush_fifo", 32'(fifo_cnt), 32'd0);
        advance();
        snap = wv_seen;
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);
        idle(4);
        drive(0, 0, '0, 0, 0);
        check("postflush_pulses", 32'(wv_seen - snap), 32'd0);
        check("postflush_credit", 32'(credit_cnt), 32'd2);
        advance();

        // Reset mid-stream drops buffered data and the pending strobe.
        do_reset();
        step(0, 1, 16'h0011, 0, 0);
        step(0, 1, 16'h0022, 0, 0);
        step(1, 1, 16'h0033, 0, 0);
        drive(0, 0, '0, 0, 0);
        check("midrst_wvalid", 32'(wvalid), 32'd0);
        check("midrst_credit", 32'(credit_cnt), 32'd10);
        check("midrst_fifo", 32'(fifo_cnt), 32'd0);
        advance();
        snap = wv_seen;
        idle(4);
        drive(0, 0, '0, 0, 0);
        check("midrst_no_pulse", 32'(wv_seen - snap), 32'd0);
        advance();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic r, v, fl, wc;
            r  = ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 39) == 0);
            wc = (m_cr < CREDITS) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            step(r, v, DW'($urandom), fl, wc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
